tx_ffe_sweep_ctrl: RTL and testbench

Sequencer that configures the TX FFE by driving its tx_setting code. On request it sweeps a programmed range of settings. For each setting it waits a settle window, then counts receiver-checker errors over a dwell window. It applies the setting with the fewest errors at the end of the sweep. Between sweeps it holds the applied setting or passes through a manual override. It sits between the run-control/host registers and tx_ffe, with err_in fed from the link's bit-error checker.

---
 rtl/tx_ffe_sweep_ctrl_pkg.sv | 24 ++
 rtl/tx_ffe_sweep_ctrl_if.sv | 33 +++
 rtl/tx_ffe_sweep_ctrl_sat_err_counter.sv | 36 +++
 rtl/tx_ffe_sweep_ctrl.sv | 163 ++++++++++++++++
 tb/tb_tx_ffe_sweep_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_ffe_sweep_ctrl_pkg.sv
// Shared types and defaults for the TX FFE sweep controller.
// Pure declarations; no logic, no latency, no flow control.
package tx_ffe_sweep_ctrl_pkg;

    localparam int TX_SETTING_WIDTH = 4;
    localparam int TX_SWEEP_SETTLE  = 64;
    localparam int TX_SWEEP_DWELL   = 1024;
    localparam int TX_SWEEP_ERR_W   = 16;

    typedef logic [TX_SETTING_WIDTH-1:0] tx_setting_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_COMPARE,
        ST_DONE
    } sweep_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tx_ffe_sweep_ctrl_if.sv
// Host/checker-side bundle of the sweep controller: control pulses, range, override, results.
// Wires only; the controller registers every output it drives here.
interface tx_ffe_sweep_ctrl_if
    import tx_ffe_sweep_ctrl_pkg::*;
#(
    parameter int ERR_WIDTH = TX_SWEEP_ERR_W
) ();

    logic                 start;
    logic                 abort;
    tx_setting_t          setting_min;
    tx_setting_t          setting_max;
    logic                 manual_en;
    tx_setting_t          manual_setting;
    logic                 err_in;
    tx_setting_t          tx_setting;
    logic                 busy;
    logic                 done;
    logic                 cfg_err;
    tx_setting_t          best_setting;
    logic [ERR_WIDTH-1:0] best_err;

    modport master (
        output start, abort, setting_min, setting_max, manual_en, manual_setting, err_in,
        input  tx_setting, busy, done, cfg_err, best_setting, best_err
    );

    modport slave (
        input  start, abort, setting_min, setting_max, manual_en, manual_setting, err_in,
        output tx_setting, busy, done, cfg_err, best_setting, best_err
    );

endinterface

// File: rtl/tx_ffe_sweep_ctrl_sat_err_counter.sv
// Saturating error counter: clear wins over enable, holds at all ones instead of wrapping.
// One-cycle latency from inc to count; no backpressure.
module sat_err_counter #(
    parameter int ERR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic                 inc_i,
    output logic [ERR_WIDTH-1:0] count_o
);

    logic [ERR_WIDTH-1:0] count_q;
    logic [ERR_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/tx_ffe_sweep_ctrl.sv
// Sweeps the TX FFE setting over a latched range, scores each by checker errors, applies the best.
// Each setting costs SETTLE+DWELL+1 cycles; start is ignored while busy, abort only acts while busy.
module tx_ffe_sweep_ctrl
    import tx_ffe_sweep_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = TX_SWEEP_SETTLE,
    parameter int DWELL_CYCLES  = TX_SWEEP_DWELL,
    parameter int ERR_WIDTH     = TX_SWEEP_ERR_W
) (
    input logic               clk,
    input logic               rst_n,
    tx_ffe_sweep_ctrl_if.slave bus
);

    localparam int TIMER_W = $clog2(max_int(SETTLE_CYCLES, DWELL_CYCLES) + 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DWELL_LAST  = TIMER_W'(DWELL_CYCLES - 1);

    sweep_state_t         state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    tx_setting_t          tx_q, tx_d;
    tx_setting_t          saved_q, saved_d;
    tx_setting_t          max_q, max_d;
    tx_setting_t          best_set_q, best_set_d;
    logic [ERR_WIDTH-1:0] best_err_q, best_err_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cfg_err_q, cfg_err_d;

    logic                 acc_clear;
    logic                 acc_enable;
    logic [ERR_WIDTH-1:0] acc;
    logic                 better;

    sat_err_counter #(
        .ERR_WIDTH (ERR_WIDTH)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (acc_clear),
        .enable_i (acc_enable),
        .inc_i    (bus.err_in),
        .count_o  (acc)
    );

    assign acc_enable = (state_q == ST_MEASURE);
    assign better     = (acc < best_err_q);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        tx_d       = tx_q;
        saved_d    = saved_q;
        max_d      = max_q;
        best_set_d = best_set_q;
        best_err_d = best_err_q;
        busy_d     = busy_q;
        done_d     = done_q;
        cfg_err_d  = cfg_err_q;
        acc_clear  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    if (bus.setting_min <= bus.setting_max) begin
                        tx_d       = bus.setting_min;
                        saved_d    = tx_q;
                        max_d      = bus.setting_max;
                        best_set_d = bus.setting_min;
                        best_err_d = '1;
                        busy_d     = 1'b1;
                        done_d     = 1'b0;
                        cfg_err_d  = 1'b0;
                        timer_d    = '0;
                        state_d    = ST_SETTLE;
                    end else begin
                        cfg_err_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = ST_DONE;
                    end
                end else if (bus.manual_en) begin
                    tx_d = bus.manual_setting;
                end
            end
            ST_SETTLE: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == SETTLE_LAST) begin
                    timer_d   = '0;
                    acc_clear = 1'b1;
                    state_d   = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == DWELL_LAST) begin
                    timer_d = '0;
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (better) begin
                    best_err_d = acc;
                    best_set_d = tx_q;
                end
                // Checked before incrementing so an all-ones max ends the sweep instead of wrapping.
                if (tx_q == max_q) begin
                    tx_d    = better ? tx_q : best_set_q;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tx_d    = tx_q + 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.abort && busy_q) begin
            tx_d    = saved_q;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            timer_d = '0;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            tx_q       <= '0;
            saved_q    <= '0;
            max_q      <= '0;
            best_set_q <= '0;
            best_err_q <= '1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            tx_q       <= tx_d;
            saved_q    <= saved_d;
            max_q      <= max_d;
            best_set_q <= best_set_d;
            best_err_q <= best_err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign bus.tx_setting   = tx_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.cfg_err      = cfg_err_q;
    assign bus.best_setting = best_set_q;
    assign bus.best_err     = best_err_q;

endmodule

// File: tb/tb_tx_ffe_sweep_ctrl.sv
// Bench for tx_ffe_sweep_ctrl: scoreboarded tx_setting steps and done events plus direct state checks.
// A second instance with a 3-bit accumulator covers saturation.
module tb_tx_ffe_sweep_ctrl;
    import tx_ffe_sweep_ctrl_pkg::*;

    localparam int EW     = 4;
    localparam int SETTLE = 4;
    localparam int DWELL  = 8;
    localparam int PER    = SETTLE + DWELL + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    tx_ffe_sweep_ctrl_if #(.ERR_WIDTH(EW)) bus ();
    tx_ffe_sweep_ctrl_if #(.ERR_WIDTH(3))  bus2 ();

    tx_ffe_sweep_ctrl #(.SETTLE_CYCLES(SETTLE), .DWELL_CYCLES(DWELL), .ERR_WIDTH(EW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    tx_ffe_sweep_ctrl #(.SETTLE_CYCLES(SETTLE), .DWELL_CYCLES(DWELL), .ERR_WIDTH(3)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct { int cyc; int val; } tx_ev_t;
    typedef struct { int cyc; int bs; int be; int ce; } done_ev_t;

    tx_ev_t   tx_sb[$];
    done_ev_t done_sb[$];
    int       exp_cur = 0;

    task automatic push_tx(input int c, input int v);
        if (v != exp_cur) begin
            tx_sb.push_back('{c, v});
            exp_cur = v;
        end
    endtask

    // Monitor: every tx_setting change and every done rise must match the next scoreboard entry.
    bit         mon_en = 1'b0;
    logic [3:0] prev_tx;
    logic       prev_done;
    tx_ev_t     te;
    done_ev_t   de;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.tx_setting !== prev_tx) begin
                if (tx_sb.size() == 0) begin
                    chk("tx_unexpected", 32'(bus.tx_setting), 32'(prev_tx));
                end else begin
                    te = tx_sb.pop_front();
                    chk("tx_val", 32'(bus.tx_setting), te.val);
                    chk("tx_cyc", cyc, te.cyc);
                end
            end
            if (bus.done && !prev_done) begin
                if (done_sb.size() == 0) begin
                    chk("done_unexpected", 32'(bus.done), 32'(prev_done));
                end else begin
                    de = done_sb.pop_front();
                    chk("done_cyc", cyc, de.cyc);
                    chk("done_best_set", 32'(bus.best_setting), de.bs);
                    chk("done_best_err", 32'(bus.best_err), de.be);
                    chk("done_cfg_err", 32'(bus.cfg_err), de.ce);
                end
            end
            prev_tx   = bus.tx_setting;
            prev_done = bus.done;
        end
    end

    // Error source: high through SETTLE and COMPARE (must be ignored), errs[k] hits per MEASURE window.
    bit err_en = 1'b0;
    int sw_t0  = 0;
    int errs[16];
    int o, k, p;
    always @(negedge clk) begin
        bus.err_in = 1'b0;
        o = cyc + 1 - sw_t0;
        if (err_en && o >= 1) begin
            k = (o - 1) / PER;
            p = (o - 1) % PER;
            if (k < 16) begin
                if (p < SETTLE || p == PER - 1) bus.err_in = 1'b1;
                else                            bus.err_in = ((p - SETTLE) < errs[k]);
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic sweep(input int mn, input int mx, input bit model, output int t);
        int be, bs, e;
        t = cyc + 1;
        bus.setting_min = 4'(mn);
        bus.setting_max = 4'(mx);
        bus.start       = 1'b1;
        sw_t0           = t;
        err_en          = 1'b1;
        if (model) begin
            be = (1 << EW) - 1;
            bs = mn;
            push_tx(t, mn);
            for (int s = mn; s <= mx; s++) begin
                e = (errs[s - mn] > be) ? ((1 << EW) - 1) : errs[s - mn];
                if (e < be) begin
                    be = e;
                    bs = s;
                end
                if (s == mx) begin
                    push_tx(t + PER * (s - mn + 1), bs);
                    done_sb.push_back('{t + PER * (s - mn + 1), bs, be, 0});
                end else begin
                    push_tx(t + PER * (s - mn + 1), s + 1);
                end
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    int t, t2;

    initial begin
        bus.start = 0; bus.abort = 0; bus.setting_min = 0; bus.setting_max = 0;
        bus.manual_en = 0; bus.manual_setting = 0;
        bus2.start = 0; bus2.abort = 0; bus2.setting_min = 0; bus2.setting_max = 0;
        bus2.manual_en = 0; bus2.manual_setting = 0; bus2.err_in = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(bus.tx_setting), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_cfg_err", 32'(bus.cfg_err), 0);
        chk("rst_best_set", 32'(bus.best_setting), 0);
        chk("rst_best_err", 32'(bus.best_err), 15);
        chk("rst_best_err_w3", 32'(bus2.best_err), 7);
        rst_n = 1'b1;
        prev_tx   = bus.tx_setting;
        prev_done = bus.done;
        mon_en    = 1'b1;

        // Saturation on the 3-bit instance: 8 errors must read 7, not wrap to 0.
        t2 = cyc + 1;
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        wait_cyc(t2 + PER - 1);
        chk("sat_done_early", 32'(bus2.done), 0);
        @(negedge clk);
        chk("sat_done", 32'(bus2.done), 1);
        chk("sat_best_err", 32'(bus2.best_err), 7);
        chk("sat_best_set", 32'(bus2.best_setting), 0);

        // Basic sweep with a mid-sweep start and range change that must be ignored.
        errs[0] = 5; errs[1] = 3; errs[2] = 1; errs[3] = 6;
        sweep(0, 3, 1'b1, t);
        chk("basic_busy", 32'(bus.busy), 1);
        chk("basic_done_low", 32'(bus.done), 0);
        wait_cyc(t + 20);
        bus.setting_min = 4'd1; bus.setting_max = 4'd1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_cyc(t + 4 * PER);
        chk("basic_done", 32'(bus.done), 1);
        chk("basic_busy_off", 32'(bus.busy), 0);
        chk("basic_best_set", 32'(bus.best_setting), 2);
        chk("basic_best_err", 32'(bus.best_err), 1);
        chk("basic_tx", 32'(bus.tx_setting), 2);

        // Tie keeps the lower setting.
        errs[0] = 2; errs[1] = 2;
        sweep(5, 6, 1'b1, t);
        wait_cyc(t + 2 * PER);
        chk("tie_best_set", 32'(bus.best_setting), 5);
        chk("tie_best_err", 32'(bus.best_err), 2);

        // Top of range: single setting, no wrap to 0.
        errs[0] = 3;
        sweep(15, 15, 1'b1, t);
        wait_cyc(t + PER);
        chk("top_done", 32'(bus.done), 1);
        chk("top_tx", 32'(bus.tx_setting), 15);
        chk("top_best_err", 32'(bus.best_err), 3);

        // Manual override, then abort ignored while not busy.
        bus.manual_en = 1'b1; bus.manual_setting = 4'd9;
        push_tx(cyc + 1, 9);
        @(negedge clk);
        chk("manual_tx", 32'(bus.tx_setting), 9);
        bus.manual_en = 1'b0; bus.manual_setting = 4'd3;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_done", 32'(bus.done), 1);

        // Abort during MEASURE of setting 1 restores the pre-sweep setting.
        errs[0] = 5; errs[1] = 3; errs[2] = 1; errs[3] = 6;
        push_tx(cyc + 1, 0);
        push_tx(cyc + 1 + PER, 1);
        push_tx(cyc + 1 + 20, 9);
        sweep(0, 3, 1'b0, t);
        wait_cyc(t + 19);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_tx", 32'(bus.tx_setting), 9);
        chk("abort_best_set", 32'(bus.best_setting), 0);
        chk("abort_best_err", 32'(bus.best_err), 5);

        // Inverted range from IDLE.
        done_sb.push_back('{cyc + 1, 0, 5, 1});
        sweep(4, 2, 1'b0, t);
        chk("cfg_done", 32'(bus.done), 1);
        chk("cfg_err", 32'(bus.cfg_err), 1);
        chk("cfg_tx", 32'(bus.tx_setting), 9);

        // Fresh sweep after abort/cfg error.
        errs[0] = 4; errs[1] = 4; errs[2] = 2; errs[3] = 7;
        sweep(0, 3, 1'b1, t);
        chk("resweep_cfg_clr", 32'(bus.cfg_err), 0);
        wait_cyc(t + 4 * PER);
        chk("resweep_best_set", 32'(bus.best_setting), 2);
        chk("resweep_best_err", 32'(bus.best_err), 2);

        // Reset during SETTLE of setting 2, then manual follows with one-cycle latency.
        errs[0] = 5; errs[1] = 3; errs[2] = 1; errs[3] = 6;
        push_tx(cyc + 1, 0);
        push_tx(cyc + 1 + PER, 1);
        push_tx(cyc + 1 + 2 * PER, 2);
        push_tx(cyc + 1 + 2 * PER + 2, 0);
        sweep(0, 3, 1'b0, t);
        wait_cyc(t + 2 * PER + 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_tx", 32'(bus.tx_setting), 0);
        chk("mrst_busy", 32'(bus.busy), 0);
        chk("mrst_done", 32'(bus.done), 0);
        chk("mrst_cfg_err", 32'(bus.cfg_err), 0);
        chk("mrst_best_set", 32'(bus.best_setting), 0);
        chk("mrst_best_err", 32'(bus.best_err), 15);
        err_en = 1'b0;
        bus.manual_en = 1'b1; bus.manual_setting = 4'd6;
        push_tx(cyc + 1, 6);
        @(negedge clk);
        chk("mrst_manual_tx", 32'(bus.tx_setting), 6);

        repeat (20) @(negedge clk);
        chk("sb_tx_empty", tx_sb.size(), 0);
        chk("sb_done_empty", done_sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
